// File: rtl/rom_stream_ctrl_pkg.sv
// Shared definitions for the ROM stream controller: default geometry,
// the 2-bit state codes and the FSM state type.
// Optional checksum output is enabled with ROM_STREAM_CSUM_EN.
package rom_stream_ctrl_pkg;

  // Default ROM geometry
  localparam int DEF_BW = 8;
  localparam int DEF_N  = 16;

  // State codes, kept as plain constants so other tooling can decode them
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    FETCH   = ST_FETCH,
    PRESENT = ST_PRESENT,
    FINISH  = ST_FINISH
  } state_t;

endpackage

// File: rtl/rom_stream_ctrl_if.sv
// Command, ROM bus and output stream signals of the ROM stream controller.
// master = controller side, slave = surrounding logic (command source,
// ROM and consumer). With ROM_STREAM_CSUM_EN the csum signal is added.
interface rom_stream_ctrl_if
  import rom_stream_ctrl_pkg::*;
#(
  parameter int BW = DEF_BW,
  parameter int N  = DEF_N
);
  localparam int AW = $clog2(N);

  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] rom_addr;
  logic [BW-1:0] rom_data;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
`ifdef ROM_STREAM_CSUM_EN
  logic [BW-1:0] csum;

  modport master (
    input  start, base_addr, count, rom_data, out_ready,
    output rom_addr, out_data, out_valid, busy, done, csum
  );

  modport slave (
    output start, base_addr, count, rom_data, out_ready,
    input  rom_addr, out_data, out_valid, busy, done, csum
  );
`else
  modport master (
    input  start, base_addr, count, rom_data, out_ready,
    output rom_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, count, rom_data, out_ready,
    input  rom_addr, out_data, out_valid, busy, done
  );
`endif

endinterface

// File: rtl/rom_addr_ctr.sv
// Loadable ROM address counter with increment enable and modulo-N wrap.
// The wrap uses an explicit compare against N-1 so non-power-of-two
// depths work. Not affected by ROM_STREAM_CSUM_EN.
module rom_addr_ctr #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [$clog2(N)-1:0] load_val_i,
  input  logic                 inc_i,
  output logic [$clog2(N)-1:0] addr_o
);
  localparam int AW = $clog2(N);

  logic [AW-1:0] addr_q;

  // Load has priority over increment; increment wraps N-1 -> 0
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= load_val_i;
    end else if (inc_i) begin
      if (addr_q == AW'(N - 1)) begin
        addr_q <= '0;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/rom_stream_ctrl.sv
// ROM stream controller: on start walks count words of a combinational ROM
// from base_addr (wrapping through 0), registers each word and offers it on
// a valid/ready stream. done pulses for one cycle when the run ends.
// Optional XOR checksum of transferred words: ROM_STREAM_CSUM_EN.
module rom_stream_ctrl
  import rom_stream_ctrl_pkg::*;
#(
  parameter int BW = DEF_BW,
  parameter int N  = DEF_N
) (
  input  logic clk,
  input  logic rst,
  rom_stream_ctrl_if.master sbus
);
  localparam int AW = $clog2(N);

  state_t        state_q, state_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [BW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          addr_load;
  logic          addr_inc;
  logic [AW-1:0] addr_q;
  logic          xfer;
`ifdef ROM_STREAM_CSUM_EN
  logic [BW-1:0] csum_q, csum_d;
`endif

  // A word leaves only while it is actually being offered
  assign xfer = valid_q & sbus.out_ready;

  rom_addr_ctr #(
    .N (N)
  ) u_addr_ctr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (addr_load),
    .load_val_i (sbus.base_addr),
    .inc_i      (addr_inc),
    .addr_o     (addr_q)
  );

  // Next-state and datapath decisions for the run sequencer
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    addr_load   = 1'b0;
    addr_inc    = 1'b0;
`ifdef ROM_STREAM_CSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (sbus.start) begin
`ifdef ROM_STREAM_CSUM_EN
          csum_d = '0;
`endif
          if (sbus.count != '0) begin
            addr_load   = 1'b1;
            remaining_d = sbus.count;
            state_d     = FETCH;
          end else begin
            // Empty run: report completion without touching the ROM
            state_d = FINISH;
          end
        end
      end
      FETCH: begin
        // ROM is combinational, so its output for addr_q is settled now
        data_d  = sbus.rom_data;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (xfer) begin
          valid_d     = 1'b0;
          remaining_d = remaining_q - 1'b1;
`ifdef ROM_STREAM_CSUM_EN
          csum_d      = csum_q ^ data_q;
`endif
          if (remaining_q == {{AW{1'b0}}, 1'b1}) begin
            state_d = FINISH;
          end else begin
            addr_inc = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
`ifdef ROM_STREAM_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
`ifdef ROM_STREAM_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign sbus.rom_addr  = addr_q;
  assign sbus.out_data  = data_q;
  assign sbus.out_valid = valid_q;
  assign sbus.busy      = (state_q != IDLE);
  assign sbus.done      = (state_q == FINISH);
`ifdef ROM_STREAM_CSUM_EN
  assign sbus.csum      = csum_q;
`endif

endmodule
